// File: rtl/vend_sequencer.sv
// Round-robin motor-power arbiter for four vending stepper channels: one motor at a time, timeout fault, settle gap.
// Optional per-channel completion counters on output vend_count when VEND_STATS_EN is defined.
module vend_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 600000000,
  parameter int unsigned GAP_CYCLES     = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic        enable,
  input  logic [3:0]  done,
  input  logic        clr_fault,
  output logic [3:0]  start,
  output logic [3:0]  active,
  output logic [3:0]  pending,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_ch
`ifdef VEND_STATS_EN
  ,
  output logic [31:0] vend_count
`endif
);

  localparam int TW = 30;
  localparam logic [TW-1:0] RUN_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_GAP,
    S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      pend_q, pend_d;
  logic [3:0]      active_q, active_d;
  logic [3:0]      start_q, start_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      ch_q, ch_d;
  logic            fault_q, fault_d;
  logic [1:0]      fault_ch_q, fault_ch_d;
  logic [3:0]      grant_oh;

  // Scan last+1 .. last+4; iterating downward lets the nearest candidate win.
  function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (pend[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    active_d   = active_q;
    start_d    = '0;
    last_d     = last_q;
    ch_d       = ch_q;
    fault_d    = fault_q;
    fault_ch_d = fault_ch_q;
    grant_oh   = '0;
    case (state_q)
      S_IDLE: begin
        if (enable && (|pend_q)) begin
          ch_d     = rr_pick(pend_q, last_q);
          grant_oh = 4'b0001 << ch_d;
          last_d   = ch_d;
          active_d = grant_oh;
          start_d  = grant_oh;
          state_d  = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (done[ch_q]) begin
          state_d  = S_GAP;
          timer_d  = '0;
          active_d = '0;
        end else if (timer_q == RUN_LAST) begin
          state_d    = S_FAULT;
          fault_d    = 1'b1;
          fault_ch_d = ch_q;
          active_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_FAULT: begin
        if (clr_fault) begin
          fault_d = 1'b0;
          timer_d = '0;
          state_d = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A request to the channel being served, or being granted right now, is dropped.
    pend_d = (pend_q | (req & ~active_q)) & ~grant_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pend_q     <= '0;
      active_q   <= '0;
      start_q    <= '0;
      last_q     <= 2'd3;
      ch_q       <= 2'd0;
      fault_q    <= 1'b0;
      fault_ch_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pend_q     <= pend_d;
      active_q   <= active_d;
      start_q    <= start_d;
      last_q     <= last_d;
      ch_q       <= ch_d;
      fault_q    <= fault_d;
      fault_ch_q <= fault_ch_d;
    end
  end

  assign start    = start_q;
  assign active   = active_q;
  assign pending  = pend_q;
  assign busy     = (state_q != S_IDLE);
  assign fault    = fault_q;
  assign fault_ch = fault_ch_q;

`ifdef VEND_STATS_EN
  logic       run_done;
  logic [7:0] cnt_q [4];

  assign run_done = (state_q == S_RUN) && done[ch_q];

  // Saturating per-channel completion counters; timeouts never reach here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (run_done && (cnt_q[ch_q] != 8'hFF)) begin
      cnt_q[ch_q] <= cnt_q[ch_q] + 8'd1;
    end
  end

  assign vend_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Arbiter/scheduler that shares the vending motor power budget across 4 stepper channels. At most one motor runs at a time. Latches debounced single-cycle vend requests per channel and grants them round-robin. For each grant: issues a one-cycle start pulse to that channel's stepper driver, waits for the driver's done pulse or a timeout, then enforces a settle gap before the next grant. Sits between the button pulse detectors and the per-channel stepper drivers.

Parameters:
TIMEOUT_CYCLES, 600000000, max cycles in RUN before fault (30-bit counter; covers a 4165-step rotation at 125001 clk/step)
GAP_CYCLES, 25000000, idle settle cycles after each completed vend (0.25 s at 100 MHz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  4  vend request pulses, one bit per channel, already debounced/single-pulsed
enable  in  1  1 = new grants allowed
done  in  4  per-channel rotation-complete pulse from stepper drivers
clr_fault  in  1  pulse; acknowledges and clears fault
start  out  4  one-hot, one-cycle start pulse to the granted driver (registered)
active  out  4  one-hot channel currently granted (START/RUN); 0 otherwise
pending  out  4  latched, not-yet-granted requests
busy  out  1  1 when state is not IDLE
fault  out  1  timeout fault flag
fault_ch  out  2  channel that timed out; valid while fault=1

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All state updates on posedge clk.
- Reset values: state=IDLE; start=0; active=0; pending=0; busy=0; fault=0; fault_ch=0; timer=0; rr pointer last=3, so ch0 has first priority.
- FSM states: IDLE, START, RUN, GAP, FAULT.
- Request latching: pending[i] set on req[i]=1 unless channel i is currently active. Requests to the active channel are dropped. Setting an already-pending bit has no effect (queue depth 1 per channel).
- IDLE: if enable=1 and pending!=0, pick the first pending channel scanning last+1, last+2, ... modulo 4. Clear its pending bit, set active, last=ch, go to START. If pending=0 or enable=0, stay in IDLE.
- START: exactly one cycle. start[ch]=1. Timer cleared. Next state is RUN.
- RUN:
  - done[ch]=1 -> GAP, timer=0, active=0.
  - Else if timer==TIMEOUT_CYCLES-1 -> FAULT, fault=1, fault_ch=ch, active=0.
  - Else timer++.
  - done bits of non-active channels are ignored in all states.
- GAP: timer counts to GAP_CYCLES-1, then IDLE.
- FAULT: hold; no grants. clr_fault=1 -> fault=0, timer=0, go to GAP. Pending bits keep latching throughout.
- enable=0 mid-vend: the current START/RUN/GAP completes normally; only the IDLE grant is blocked.
- Latency: req sampled at edge n -> pending set after edge n -> START entered after edge n+1, so start visible in cycle n+2 when idle.
- Simultaneous events:
  - req[i] in the same cycle its bit is granted: dropped, since the channel becomes active.
  - done and timeout in the same cycle: done wins.
  - clr_fault outside FAULT: ignored.
- Reset mid-operation: immediate return to reset values. Pending requests are discarded and start is deasserted.

Optional Feature:
VEND_STATS_EN
- Defined: adds output vend_count (32 bits, 8 bits per channel, ch0 in [7:0]). Each field increments on a RUN->GAP transition for its channel and saturates at 255. Timeouts do not count. Fields reset to 0 on rst.
- Not defined: the port and counters are absent; behaviour is otherwise identical.

Test Plan:
Overrides for all scenarios: TIMEOUT_CYCLES=100, GAP_CYCLES=10.
1. Reset, enable=1, req=0001 at cycle 0 -> pending=0001 at cycle 1; start=0001 for exactly cycle 2; active=0001 until done[0] pulse; 10 GAP cycles; then busy=0.
2. req=1111 in one cycle -> grants in order ch0, ch1, ch2, ch3. Each done pulse is followed by 10 gap cycles, and each start is a single-cycle one-hot pulse.
3. Hold ch0 active; pulse req[0] and req[2] -> req[0] dropped, pending=0100; next grant ch2 (not ch0 again).
4. Grant ch1, no done -> fault=1, fault_ch=1 after 100 RUN cycles; no start while faulted even with pending=1000; clr_fault -> 10 gap cycles -> ch3 granted.
5. enable=0 with pending=0011 -> no start for 50 cycles; enable=1 -> ch0 granted. Also: done[0] and timeout coinciding -> GAP, no fault.
6. Assert rst during RUN with pending=1010 -> next cycle active=0, pending=0, start=0, busy=0. With VEND_STATS_EN: 300 ch0 completions -> vend_count[7:0]=255.
